// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one execute-stage ALU between two
//            requesters with registered ALU inputs and a valid/ready response.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4:0]       req0_op,
  input  logic [1:0]       req0_funct,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4:0]       req1_op,
  input  logic [1:0]       req1_funct,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [4:0]       alu_op,
  output logic [1:0]       alu_funct,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp0_ready,
  input  logic             resp1_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  logic [4:0]       op_q, op_d;
  logic [1:0]       funct_q, funct_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             w_sel;
  logic             w_acc0, w_acc1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      op_q    <= '0;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

  // prio only breaks ties; a lone requester wins regardless
  assign w_sel = (req0_valid && req1_valid) ? prio_q : req1_valid;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    op_d    = op_q;
    funct_d = funct_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    w_acc0  = 1'b0;
    w_acc1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          w_acc0  = ~w_sel;
          w_acc1  = w_sel;
          grant_d = w_sel;
          prio_d  = ~w_sel;
          op_d    = w_sel ? req1_op    : req0_op;
          funct_d = w_sel ? req1_funct : req0_funct;
          a_d     = w_sel ? req1_a     : req0_a;
          b_d     = w_sel ? req1_b     : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_result;
        state_d = RESP;
      end
      RESP: begin
        if (grant_q ? resp1_ready : resp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Keep the combinational readies quiet while reset is held
  assign req0_ready  = w_acc0 & ~rst;
  assign req1_ready  = w_acc1 & ~rst;
  assign alu_op      = op_q;
  assign alu_funct   = funct_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign resp_data   = data_q;
  assign resp0_valid = (state_q == RESP) && !grant_q;
  assign resp1_valid = (state_q == RESP) && grant_q;
  assign busy        = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed, self-checking bench for alu_arbiter with a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  localparam int WIDTH = 16;
  localparam logic [4:0] OP_ADD = 5'b11011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, resp0_ready = 0, resp1_ready = 0;
  logic [4:0] req0_op = '0, req1_op = '0;
  logic [1:0] req0_funct = '0, req1_funct = '0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, resp0_valid, resp1_valid, busy;
  logic [4:0] alu_op;
  logic [1:0] alu_funct;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, resp_data;

  int n_vec = 0;
  int n_fail = 0;
  int glog[$];

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [4:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (op == OP_ADD) ? a + b : a - b;
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_funct(req0_funct), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_funct(req1_funct), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_funct(alu_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_data(resp_data),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Transaction-level model: one outstanding operation, idle/executing/answering
  int               m_phase = 0;
  bit               m_id = 0, m_prio = 0;
  logic [4:0]       m_op = '0;
  logic [1:0]       m_funct = '0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_data = '0;

  function automatic bit m_pick();
    if (req0_valid && req1_valid) return m_prio;
    return req1_valid;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_id = 0; m_prio = 0;
      m_op = '0; m_funct = '0; m_a = '0; m_b = '0; m_data = '0;
    end else if (m_phase == 0) begin
      if (req0_valid || req1_valid) begin
        m_id    = m_pick();
        m_prio  = !m_id;
        m_op    = m_id ? req1_op : req0_op;
        m_funct = m_id ? req1_funct : req0_funct;
        m_a     = m_id ? req1_a : req0_a;
        m_b     = m_id ? req1_b : req0_b;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_data  = ref_alu(m_op, m_a, m_b);
      m_phase = 2;
    end else if (m_id ? resp1_ready : resp0_ready) begin
      m_phase = 0;
    end
  end

  // Per-cycle comparison plus a log of the grants the DUT actually gives
  always @(negedge clk) begin
    if (!rst) begin
      bit idle_req;
      idle_req = (m_phase == 0) && (req0_valid || req1_valid);
      check("req0_ready", {31'd0, req0_ready}, {31'd0, idle_req && !m_pick()});
      check("req1_ready", {31'd0, req1_ready}, {31'd0, idle_req && m_pick()});
      check("busy", {31'd0, busy}, {31'd0, m_phase != 0});
      check("alu_op", {27'd0, alu_op}, {27'd0, m_op});
      check("alu_funct", {30'd0, alu_funct}, {30'd0, m_funct});
      check("alu_a", {16'd0, alu_a}, {16'd0, m_a});
      check("alu_b", {16'd0, alu_b}, {16'd0, m_b});
      check("resp0_valid", {31'd0, resp0_valid}, {31'd0, m_phase == 2 && !m_id});
      check("resp1_valid", {31'd0, resp1_valid}, {31'd0, m_phase == 2 && m_id});
      if (m_phase == 2) check("resp_data", {16'd0, resp_data}, {16'd0, m_data});
      if (req0_valid && req0_ready) glog.push_back(0);
      if (req1_valid && req1_ready) glog.push_back(1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    tick();
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_resp_data", {16'd0, resp_data}, 32'd0);
    check("rst_alu_op", {27'd0, alu_op}, 32'd0);
    rst = 1'b0;

    // Requester 0 alone, ADD 3+4
    req0_op = OP_ADD; req0_funct = 2'b00; req0_a = 16'h0003; req0_b = 16'h0004;
    req0_valid = 1;
    #1 check("t1_ready", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 0;
    #1 check("t1_alu_a", {16'd0, alu_a}, 32'h3);
    check("t1_alu_b", {16'd0, alu_b}, 32'h4);
    check("t1_alu_op", {27'd0, alu_op}, 32'h1b);
    tick();
    #1 check("t1_resp0", {31'd0, resp0_valid}, 32'd1);
    check("t1_resp1", {31'd0, resp1_valid}, 32'd0);
    check("t1_data", {16'd0, resp_data}, 32'h7);
    resp0_ready = 1; tick(); resp0_ready = 0;

    // Simultaneous requests after reset; requester 1 issues HALT (subtracts)
    do_reset();
    req0_op = OP_ADD; req0_a = 16'h0010; req0_b = 16'h0020;
    req1_op = 5'b00000; req1_funct = 2'b10; req1_a = 16'h0100; req1_b = 16'h0005;
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    #1 check("t2_r0", {31'd0, req0_ready}, 32'd1);
    check("t2_r1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 0;
    tick();
    #1 check("t2_resp0_data", {16'd0, resp_data}, 32'h30);
    tick();
    #1 check("t2_r1_after_hs", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 0;
    tick();
    #1 check("t2_resp1", {31'd0, resp1_valid}, 32'd1);
    check("t2_resp1_data", {16'd0, resp_data}, 32'h00fb);
    tick(); resp0_ready = 0; resp1_ready = 0;

    // Back-pressure on requester 1 while requester 0 keeps asking
    req1_op = OP_ADD; req1_a = 16'h1111; req1_b = 16'h2222; req1_valid = 1;
    tick(); req1_valid = 0; req0_valid = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1 check("t3_valid", {31'd0, resp1_valid}, 32'd1);
      check("t3_data", {16'd0, resp_data}, 32'h3333);
      check("t3_busy", {31'd0, busy}, 32'd1);
      check("t3_r0", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    resp1_ready = 1;
    #1 check("t3_hs_valid", {31'd0, resp1_valid}, 32'd1);
    tick(); resp1_ready = 0; req0_valid = 0;
    #1 check("t3_idle", {31'd0, busy}, 32'd0);

    // Round-robin with both continuously valid
    glog.delete();
    req0_valid = 1; req1_valid = 1; resp0_ready = 1; resp1_ready = 1;
    for (int c = 0; c < 60 && glog.size() < 6; c++) tick();
    req0_valid = 0; req1_valid = 0;
    check("t4_count", glog.size(), 32'd6);
    for (int i = 0; i < 6 && i < glog.size(); i++)
      check("t4_order", glog[i], i % 2);
    repeat (4) tick();
    resp0_ready = 0; resp1_ready = 0;

    // Reset during EXEC after requester 0 leaves prio pointing at 1
    req0_a = 16'h0042; req0_valid = 1;
    tick(); req0_valid = 0;
    rst = 1;
    #1 check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_alu_a", {16'd0, alu_a}, 32'd0);
    check("t5_alu_op", {27'd0, alu_op}, 32'd0);
    check("t5_resp0", {31'd0, resp0_valid}, 32'd0);
    tick(); rst = 0; resp0_ready = 1;
    tick(); tick();
    #1 check("t5_no_resp", {31'd0, resp0_valid}, 32'd0);
    req0_valid = 1; req1_valid = 1;
    #1 check("t5_prio0", {31'd0, req0_ready}, 32'd1);
    check("t5_prio1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 0; req1_valid = 0;
    tick(); tick(); resp0_ready = 0;

    // Operand changed after accept must not leak into execution
    req0_op = OP_ADD; req0_a = 16'h1234; req0_b = 16'h0011; req0_valid = 1;
    tick(); req0_valid = 0; req0_a = 16'hffff;
    #1 check("t6_alu_a", {16'd0, alu_a}, 32'h1234);
    tick();
    #1 check("t6_data", {16'd0, resp_data}, 32'h1245);
    resp0_ready = 1; tick(); resp0_ready = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
